// File: rtl/clock_pkg.sv
// Shared constants and types for the digital clock's button front end.
// Default cycle counts are derived from millisecond figures at the system clock rate.
package clock_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int CYCLES_PER_MS = CLK_HZ / 1000;

    localparam int DEBOUNCE_MS = 10;
    localparam int HOLD_MS     = 500;
    localparam int REPEAT_MS   = 200;

    localparam int DEFAULT_DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS;
    localparam int DEFAULT_HOLD_CYCLES     = CYCLES_PER_MS * HOLD_MS;
    localparam int DEFAULT_REPEAT_CYCLES   = CYCLES_PER_MS * REPEAT_MS;

    // Auto-repeat state of one button channel.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Larger of two integers, used to size the shared hold/repeat counter.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-FF synchroniser, counter debounce, press/release
// pulses and an auto-repeat step generator. All outputs come straight from flops.
module btn_channel
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_step
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HMAX = maxInt(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_dcnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_step;
    logic [HW-1:0] r_hcnt;
    rep_state_t    r_state;

    logic          w_expire;
    logic          w_rise;
    logic          w_fall;
    rep_state_t    w_nextState;
    logic [HW-1:0] w_nextHcnt;
    logic          w_nextStep;

    // Detect the cycle on which the debounced level is about to flip, and in which direction.
    always_comb begin
        w_expire = (r_s2 != r_level) && (r_dcnt == D_LAST);
        w_rise   = w_expire &&  r_s2;
        w_fall   = w_expire && !r_s2;
    end

    // Synchronise the raw pin, run the debounce counter and register the edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= i_btn;
            r_s2      <= r_s1;
            r_press   <= w_rise;
            r_release <= w_fall;
            if (r_s2 == r_level) begin
                r_dcnt <= '0;
            end else if (w_expire) begin
                r_level <= r_s2;
                r_dcnt  <= '0;
            end else begin
                r_dcnt <= r_dcnt + DW'(1);
            end
        end
    end

    // Auto-repeat state, hold/repeat counter and step pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_hcnt  <= w_nextHcnt;
            r_step  <= w_nextStep;
        end
    end

    // Next-state logic; a debounced release always beats a coincident repeat expiry.
    always_comb begin
        w_nextState = r_state;
        w_nextHcnt  = r_hcnt;
        w_nextStep  = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextHcnt = '0;
                if (w_rise) begin
                    w_nextStep  = 1'b1;
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_fall) begin
                    w_nextState = IDLE;
                    w_nextHcnt  = '0;
                end else if (r_hcnt == H_LAST) begin
                    w_nextStep  = 1'b1;
                    w_nextHcnt  = '0;
                    w_nextState = REPEAT;
                end else begin
                    w_nextHcnt = r_hcnt + HW'(1);
                end
            end
            REPEAT: begin
                if (w_fall) begin
                    w_nextState = IDLE;
                    w_nextHcnt  = '0;
                end else if (r_hcnt == R_LAST) begin
                    w_nextStep = 1'b1;
                    w_nextHcnt = '0;
                end else begin
                    w_nextHcnt = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextHcnt  = '0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_step    = r_step;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw clock-setting push-buttons into clean levels, edge pulses
// and auto-repeat steps. Each button is handled by its own independent channel.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_step
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .i_btn     (btn_in[gi]),
            .o_level   (btn_level[gi]),
            .o_press   (btn_press[gi]),
            .o_release (btn_release[gi]),
            .o_step    (btn_step[gi])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat counts.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_button_conditioner;
    import clock_pkg::*;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int REP   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_step;

    int nAsserts = 0;
    int nFails   = 0;

    button_conditioner #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_step    (btn_step)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expectation for all four outputs of channel 0.
    task automatic checkCh0(input string tag, input logic lvl, input logic prs, input logic rel, input logic stp);
        checkOutput({tag, "_level"},   32'(btn_level[0]),   32'(lvl));
        checkOutput({tag, "_press"},   32'(btn_press[0]),   32'(prs));
        checkOutput({tag, "_release"}, 32'(btn_release[0]), 32'(rel));
        checkOutput({tag, "_step"},    32'(btn_step[0]),    32'(stp));
    endtask

    initial begin
        logic [9:0] bouncePat;
        reset  = 1'b1;
        btn_in = '0;

        // Reset state
        applyStimulus(2);
        checkOutput("rst_level",   32'(btn_level),   32'd0);
        checkOutput("rst_press",   32'(btn_press),   32'd0);
        checkOutput("rst_release", 32'(btn_release), 32'd0);
        checkOutput("rst_step",    32'(btn_step),    32'd0);
        reset = 1'b0;
        applyStimulus(2);

        // Clean press: visible after edge 6, press for one cycle only
        btn_in = 2'b01;
        applyStimulus(5);
        checkCh0("press_e5", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        checkCh0("press_e6", 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("press_ch1_level", 32'(btn_level[1]), 32'd0);
        checkOutput("press_ch1_press", 32'(btn_press[1]), 32'd0);

        // Hold: steps at P+8, P+11, P+14, P+17
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(1);
            checkOutput($sformatf("hold_step_k%0d", k), 32'(btn_step[0]),
                        32'((k == 8) || (k == 11) || (k == 14) || (k == 17)));
            checkOutput($sformatf("hold_press_k%0d", k), 32'(btn_press[0]), 32'd0);
        end

        // Release: repeats continue until the debounced fall six edges later
        btn_in = 2'b00;
        for (int k = 20; k <= 24; k++) begin
            applyStimulus(1);
            checkOutput($sformatf("rel_step_k%0d", k), 32'(btn_step[0]), 32'((k == 20) || (k == 23)));
            checkOutput($sformatf("rel_level_k%0d", k), 32'(btn_level[0]), 32'd1);
        end
        applyStimulus(1);
        checkCh0("rel_e6", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rel_state_idle", 32'(dut.g_chan[0].u_channel.r_state), 32'(IDLE));
        applyStimulus(1);
        checkCh0("rel_e7", 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounce: 3 high, 1 low, 2 high, then low -- never debounced
        bouncePat = 10'b0000110111;
        for (int k = 0; k < 10; k++) begin
            btn_in[0] = bouncePat[k];
            applyStimulus(1);
            checkOutput($sformatf("bounce_level_%0d", k), 32'(btn_level[0]), 32'd0);
            checkOutput($sformatf("bounce_step_%0d", k),  32'(btn_step[0]),  32'd0);
        end
        checkOutput("bounce_dcnt", 32'(dut.g_chan[0].u_channel.r_dcnt), 32'd0);

        // Release coincident with repeat expiry at P+14
        btn_in = 2'b01;
        applyStimulus(6);
        checkCh0("co_press", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(8);
        checkOutput("co_first_repeat", 32'(btn_step[0]), 32'd1);
        btn_in = 2'b00;
        applyStimulus(3);
        checkOutput("co_step_k11", 32'(btn_step[0]), 32'd1);
        applyStimulus(3);
        checkCh0("co_release_k14", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1);
        checkCh0("co_after_k15", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-repeat with the button still held
        applyStimulus(2);
        btn_in = 2'b01;
        applyStimulus(16);
        checkOutput("mid_level", 32'(btn_level[0]), 32'd1);
        reset = 1'b1;
        applyStimulus(1);
        checkCh0("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(5);
        checkCh0("redeb_e5", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1);
        checkCh0("redeb_e6", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1);
        checkCh0("redeb_e7", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("end_ch1_level", 32'(btn_level[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
